// File: rtl/ex_arith_unit.sv
// Execute-stage arithmetic: ALU, PC+4 adder, branch-target adder, branch resolve
// and a free-running cycle counter, all captured into one output register set.
module ex_arith_unit #(
  parameter int WIDTH     = 64,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     alu_a,
  input  logic [WIDTH-1:0]     alu_b,
  input  logic [1:0]           alu_op,
  input  logic [WIDTH-1:0]     pc,
  input  logic [WIDTH-1:0]     imm,
  input  logic                 branch,
  output logic [WIDTH-1:0]     alu_result,
  output logic                 zero,
  output logic [WIDTH-1:0]     pc_plus4,
  output logic [WIDTH-1:0]     branch_target,
  output logic                 take_branch,
  output logic [WIDTH-1:0]     next_pc,
  output logic [CNT_WIDTH-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic [WIDTH-1:0] pc4;
    logic [WIDTH-1:0] tgt;
    logic             take;
    logic [WIDTH-1:0] npc;
  } ex_rsp_t;

  ex_rsp_t nxt, q;

  always_comb begin
    nxt = '0;
    unique case (alu_op_e'(alu_op))
      OP_ADD:  nxt.res = alu_a + alu_b;
      OP_SUB:  nxt.res = alu_a - alu_b;
      OP_AND:  nxt.res = alu_a & alu_b;
      OP_OR:   nxt.res = alu_a | alu_b;
      default: nxt.res = '0;
    endcase
    nxt.zero = (nxt.res == '0);
    nxt.pc4  = pc + WIDTH'(4);
    // Logical shift: imm MSB falls off, target wraps modulo 2^WIDTH.
    nxt.tgt  = pc + {imm[WIDTH-2:0], 1'b0};
    nxt.take = branch & nxt.zero;
    nxt.npc  = nxt.take ? nxt.tgt : nxt.pc4;
  end

  // Reset value keeps zero consistent with a cleared result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q         <= '0;
      q.zero    <= 1'b1;
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
      if (en) q <= nxt;
    end
  end

  assign alu_result    = q.res;
  assign zero          = q.zero;
  assign pc_plus4      = q.pc4;
  assign branch_target = q.tgt;
  assign take_branch   = q.take;
  assign next_pc       = q.npc;

endmodule

// File: tb/tb_ex_arith_unit.sv
// Self-checking bench for ex_arith_unit: directed cases from the block's rules
// plus random operations, checked against a plain-arithmetic reference model.
module tb_ex_arith_unit;

  logic        clk;
  logic        rst;
  logic        en;
  logic [63:0] a, b, pc, imm;
  logic [1:0]  op;
  logic        br;

  logic [63:0] alu_result, pc_plus4, branch_target, next_pc;
  logic        zero, take_branch;
  logic [31:0] cycle_cnt;

  int compared = 0;
  int mism     = 0;

  // reference state
  logic [63:0] m_res, m_pc4, m_tgt, m_npc;
  logic        m_zero, m_take;
  logic [31:0] m_cnt;

  ex_arith_unit #(.WIDTH(64), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .en(en),
    .alu_a(a), .alu_b(b), .alu_op(op), .pc(pc), .imm(imm), .branch(br),
    .alu_result(alu_result), .zero(zero), .pc_plus4(pc_plus4),
    .branch_target(branch_target), .take_branch(take_branch),
    .next_pc(next_pc), .cycle_cnt(cycle_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] alu_ref(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
    case (o)
      2'd0:    return x + y;
      2'd1:    return x + ~y + 64'd1;
      2'd2:    return x & y;
      default: return x | y;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [63:0] ia, input logic [63:0] ib, input logic [1:0] iop,
                        input logic [63:0] ipc, input logic [63:0] iimm, input logic ibr);
    a = ia; b = ib; op = iop; pc = ipc; imm = iimm; br = ibr;
  endtask

  task automatic rand_in();
    logic [63:0] ra;
    ra = {$urandom, $urandom};
    set_in(ra, ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom},
           2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
           1'($urandom_range(0, 1)));
  endtask

  // one clock edge: advance model with the inputs held across the edge, then compare
  task automatic step();
    @(posedge clk);
    if (!rst) begin
      m_res = 64'd0; m_zero = 1'b1; m_pc4 = 64'd0; m_tgt = 64'd0;
      m_take = 1'b0; m_npc = 64'd0; m_cnt = 32'd0;
    end else begin
      m_cnt = m_cnt + 32'd1;
      if (en) begin
        m_res  = alu_ref(op, a, b);
        m_zero = (m_res == 64'd0);
        m_pc4  = pc + 64'd4;
        m_tgt  = pc + imm * 64'd2;
        m_take = br && m_zero;
        m_npc  = m_take ? m_tgt : m_pc4;
      end
    end
    #1;
    check("alu_result",    alu_result,    m_res);
    check("zero",          {63'd0, zero}, {63'd0, m_zero});
    check("pc_plus4",      pc_plus4,      m_pc4);
    check("branch_target", branch_target, m_tgt);
    check("take_branch",   {63'd0, take_branch}, {63'd0, m_take});
    check("next_pc",       next_pc,       m_npc);
    check("cycle_cnt",     {32'd0, cycle_cnt}, {32'd0, m_cnt});
  endtask

  initial begin
    m_res = '0; m_zero = 1'b1; m_pc4 = '0; m_tgt = '0; m_take = 1'b0; m_npc = '0; m_cnt = '0;

    // reset for two edges with arbitrary inputs
    rst = 1'b0; en = 1'b1;
    rand_in(); step();
    rand_in(); step();
    check("rst_result", alu_result, 64'd0);
    check("rst_zero", {63'd0, zero}, 64'd1);
    check("rst_npc", next_pc, 64'd0);

    rst = 1'b1;
    rand_in(); step();
    rand_in(); step();
    rand_in(); step();
    check("cnt_after3", {32'd0, cycle_cnt}, 64'd3);

    // ADD wrap and normal add
    set_in(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 64'h0, 64'h0, 1'b0); step();
    check("add_wrap", alu_result, 64'd0);
    check("add_wrap_zero", {63'd0, zero}, 64'd1);
    set_in(64'd5, 64'd7, 2'b00, 64'h0, 64'h0, 1'b0); step();
    check("add_5_7", alu_result, 64'd12);

    set_in(64'hF0, 64'h3C, 2'b01, 64'h0, 64'h0, 1'b0); step();
    check("sub_f0_3c", alu_result, 64'hB4);
    set_in(64'hF0, 64'h3C, 2'b10, 64'h0, 64'h0, 1'b0); step();
    check("and_f0_3c", alu_result, 64'h30);
    set_in(64'hF0, 64'h3C, 2'b11, 64'h0, 64'h0, 1'b0); step();
    check("or_f0_3c", alu_result, 64'hFC);
    set_in(64'd3, 64'd5, 2'b01, 64'h0, 64'h0, 1'b0); step();
    check("sub_3_5", alu_result, 64'hFFFF_FFFF_FFFF_FFFE);

    // taken branch
    set_in(64'd42, 64'd42, 2'b01, 64'h100, 64'h10, 1'b1); step();
    check("tk_target", branch_target, 64'h120);
    check("tk_npc", next_pc, 64'h120);
    check("tk_pc4", pc_plus4, 64'h104);
    // not taken, negative offset
    set_in(64'd42, 64'd41, 2'b01, 64'h100, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1); step();
    check("nt_target", branch_target, 64'hF0);
    check("nt_npc", next_pc, 64'h104);
    // branch=0 but zero=1
    set_in(64'd9, 64'd9, 2'b01, 64'h200, 64'h40, 1'b0); step();
    check("nobr_npc", next_pc, 64'h204);
    // imm MSB discarded by the shift; pc+4 wraps
    set_in(64'd1, 64'd1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFE, 64'h8000_0000_0000_0001, 1'b1); step();
    check("msb_target", branch_target, 64'h0);
    check("pc4_wrap", pc_plus4, 64'h2);

    // random operations, with occasional stalls
    for (int i = 0; i < 200; i++) begin
      en = ($urandom_range(0, 4) != 0);
      rand_in(); step();
    end

    // stall holds outputs, counter keeps running
    en = 1'b1;
    set_in(64'd1, 64'd1, 2'b00, 64'h300, 64'h4, 1'b0); step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_in(); step();
    end
    check("stall_hold", alu_result, 64'd2);

    // reset during stall clears outputs
    rst = 1'b0;
    rand_in(); step();
    check("stall_rst", alu_result, 64'd0);
    rst = 1'b1; en = 1'b1;
    rand_in(); step();
    check("post_rst_cnt", {32'd0, cycle_cnt}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
